// File: rtl/sw_word_fifo.sv
// rtl/sw_word_fifo.sv - hex-digit entry register feeding a first-word-fall-through word FIFO
// Digits shift into cur_word MSB-first; a commit pushes the finished word for the CPU to drain.
module sw_word_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p,
  input  logic [3:0]    h,
  input  logic          commit,
  input  logic          bksp,
  input  logic          rd,
  input  logic          clr_ovf,
  output logic [31:0]   cur_word,
  output logic [3:0]    ndig,
  output logic [31:0]   rdata,
  output logic          valid,
  output logic          full,
  output logic [AW:0]   count,
  output logic          ovf
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic          commit_req;
  logic          push;
  logic          pop;
  logic          commit_fail;
  logic [31:0]   cur_word_nxt;
  logic [3:0]    ndig_nxt;

  assign full  = (count == FULL_CNT);
  assign valid = (count != '0);
  assign rdata = valid ? mem[rd_ptr] : 32'h0;

  // A full FIFO still accepts a commit when the CPU pops in the same cycle.
  assign commit_req  = commit && (ndig != 4'd0);
  assign pop         = rd && valid;
  assign push        = commit_req && (!full || rd);
  assign commit_fail = commit_req && full && !rd;

  always_comb begin
    cur_word_nxt = cur_word;
    ndig_nxt     = ndig;
    if (push) begin
      if (p) begin
        cur_word_nxt = {28'h0, h};
        ndig_nxt     = 4'd1;
      end else begin
        cur_word_nxt = 32'h0;
        ndig_nxt     = 4'd0;
      end
    end else if (p) begin
      cur_word_nxt = {cur_word[27:0], h};
      ndig_nxt     = (ndig == 4'd8) ? 4'd8 : ndig + 4'd1;
    end else if (bksp && !commit && (ndig != 4'd0)) begin
      cur_word_nxt = {4'h0, cur_word[31:4]};
      ndig_nxt     = ndig - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_word <= 32'h0;
      ndig     <= 4'd0;
    end else begin
      cur_word <= cur_word_nxt;
      ndig     <= ndig_nxt;
    end
  end

  // Storage is not reset; rdata is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cur_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A lost commit outranks a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (commit_fail) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sw_word_fifo.sv
// tb/tb_sw_word_fifo.sv - directed scoreboard bench for sw_word_fifo
// Stimulus pushes expected words; a negedge monitor checks every popped head word.
module tb_sw_word_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        p, commit, bksp, rd, clr_ovf;
  logic [3:0]  h;
  logic [31:0] cur_word;
  logic [3:0]  ndig;
  logic [31:0] rdata;
  logic        valid, full, ovf;
  logic [2:0]  count;

  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  sw_word_fifo #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst), .p(p), .h(h), .commit(commit), .bksp(bksp),
    .rd(rd), .clr_ovf(clr_ovf), .cur_word(cur_word), .ndig(ndig),
    .rdata(rdata), .valid(valid), .full(full), .count(count), .ovf(ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change at posedge+1, held through the next rising edge, then released.
  task automatic cyc(input logic p_, input logic [3:0] h_, input logic c_,
                     input logic b_, input logic r_, input logic clr_);
    p = p_; h = h_; commit = c_; bksp = b_; rd = r_; clr_ovf = clr_;
    @(posedge clk);
    #1;
    p = 1'b0; h = 4'h0; commit = 1'b0; bksp = 1'b0; rd = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic digit(input logic [3:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst && rd && valid) begin
      if (sb.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL pop_unexpected: got %h expected no pop", rdata);
      end else begin
        check("pop_rdata", rdata, sb.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    p = 1'b0; h = 4'h0; commit = 1'b0; bksp = 1'b0; rd = 1'b0; clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_cur", cur_word, 32'h0);
    check("rst_ndig", {28'h0, ndig}, 32'h0);
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_count", {29'h0, count}, 32'h0);
    check("rst_rdata", rdata, 32'h0);

    // 1: basic entry and commit
    digit(4'h1); digit(4'h2); digit(4'h3);
    check("t1_cur", cur_word, 32'h123);
    check("t1_ndig", {28'h0, ndig}, 32'd3);
    sb.push_back(32'h123);
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t1_valid", {31'h0, valid}, 32'h1);
    check("t1_rdata", rdata, 32'h123);
    check("t1_cur0", cur_word, 32'h0);
    check("t1_ndig0", {28'h0, ndig}, 32'h0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t1_empty", {29'h0, count}, 32'h0);
    check("t1_rdata0", rdata, 32'h0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("empty_commit_count", {29'h0, count}, 32'h0);
    check("empty_commit_ovf", {31'h0, ovf}, 32'h0);

    // 2: nine digits then backspace
    for (int i = 1; i <= 9; i++) digit(4'(i));
    check("t2_cur9", cur_word, 32'h23456789);
    check("t2_ndig9", {28'h0, ndig}, 32'd8);
    repeat (3) cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t2_cur_bk", cur_word, 32'h00023456);
    check("t2_ndig_bk", {28'h0, ndig}, 32'd5);
    repeat (6) cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t2_cur_clr", cur_word, 32'h0);
    check("t2_ndig_clr", {28'h0, ndig}, 32'h0);

    // 3: fill, overflow (set beats clear), commit alongside pop
    for (int i = 10; i <= 13; i++) begin
      digit(4'(i));
      sb.push_back(32'(i));
      cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    check("t3_full", {31'h0, full}, 32'h1);
    check("t3_count4", {29'h0, count}, 32'd4);
    digit(4'hE);
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("t3_ovf", {31'h0, ovf}, 32'h1);
    check("t3_cur_kept", cur_word, 32'hE);
    check("t3_ndig_kept", {28'h0, ndig}, 32'd1);
    check("t3_count_ovf", {29'h0, count}, 32'd4);
    sb.push_back(32'hE);
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t3_count_rw", {29'h0, count}, 32'd4);
    check("t3_rdata_b", rdata, 32'hB);
    check("t3_cur_rw", cur_word, 32'h0);

    // 4: drain plus an extra pop while empty
    repeat (5) cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t4_count0", {29'h0, count}, 32'h0);
    check("t4_valid0", {31'h0, valid}, 32'h0);
    check("t4_ovf_held", {31'h0, ovf}, 32'h1);
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t4_ovf_clr", {31'h0, ovf}, 32'h0);

    // 5: commit+p and p+bksp
    digit(4'h5);
    sb.push_back(32'h5);
    cyc(1'b1, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t5_cur", cur_word, 32'h7);
    check("t5_ndig", {28'h0, ndig}, 32'd1);
    check("t5_count", {29'h0, count}, 32'd1);
    check("t5_rdata", rdata, 32'h5);
    cyc(1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t5_pbk_cur", cur_word, 32'h78);
    check("t5_pbk_ndig", {28'h0, ndig}, 32'd2);
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);

    // 6: failed commit+p keeps the word and shifts the digit; then async reset
    repeat (2) cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      digit(4'(i));
      sb.push_back(32'(i));
      cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    digit(4'h9);
    cyc(1'b1, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t6_cur_fail", cur_word, 32'h96);
    check("t6_ndig_fail", {28'h0, ndig}, 32'd2);
    check("t6_ovf", {31'h0, ovf}, 32'h1);
    repeat (2) cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t6_count2", {29'h0, count}, 32'd2);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_cur", cur_word, 32'h0);
    check("t6_rst_ndig", {28'h0, ndig}, 32'h0);
    check("t6_rst_rdata", rdata, 32'h0);
    check("t6_rst_flags", {29'h0, valid, full, ovf}, 32'h0);
    check("t6_rst_count", {29'h0, count}, 32'h0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
